sprite_path_mover: RTL and testbench

- Parametrised successor of the single-sprite diagonal mover. Steps one sprite one pixel diagonally per tick.
- Validates each candidate position against a run-time-loadable table of NUM_SEG diagonal path segments, scanned one segment per cycle.
- Sequences erase/draw handshakes with the sprite drawer FSM.
- Sits between the input/button logic and the sprite drawer; x/y feed the drawer.

---
 rtl/sprite_path_mover.sv | 186 ++++++++++++++++++
 tb/tb_sprite_path_mover.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/sprite_path_mover.sv
// Steps one sprite diagonally per tick, validating each step against a loadable path-segment table.
// Optional portal jump is compiled in when SPRITE_PORTAL_EN is defined.
module sprite_path_mover #(
   parameter int X_W      = 9,
   parameter int Y_W      = 8,
   parameter int NUM_SEG  = 8,
   parameter int TICK_DIV = 6250000,
   parameter int START_X  = 96,
   parameter int START_Y  = 222,
   localparam int SEG_W   = (NUM_SEG > 1) ? $clog2(NUM_SEG) : 1
) (
   input  logic               clock,
   input  logic               resetn,
   input  logic               move,
   input  logic [1:0]         dir,
   input  logic               cfg_we,
   input  logic [SEG_W-1:0]   cfg_idx,
   input  logic [3*X_W+1:0]   cfg_wdata,
   input  logic               erase_done,
   input  logic               draw_done,
`ifdef SPRITE_PORTAL_EN
   input  logic [X_W-1:0]     portal_src_x,
   input  logic [Y_W-1:0]     portal_src_y,
   input  logic [X_W-1:0]     portal_dst_x,
   input  logic [Y_W-1:0]     portal_dst_y,
`endif
   output logic [X_W-1:0]     x,
   output logic [Y_W-1:0]     y,
   output logic               erase_req,
   output logic               draw_req,
   output logic               busy,
   output logic               move_rejected
);

   localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);
   localparam logic [SEG_W-1:0] SEG_LAST = SEG_W'(NUM_SEG - 1);
   localparam logic [SEG_W:0]   SEG_CNT  = (SEG_W + 1)'(NUM_SEG);
   localparam int PAD = X_W + 1 - Y_W;

   typedef enum logic [2:0] {IDLE, CHECK, ERASE, UPDATE, DRAW} state_t;

   state_t           state, state_n;
   logic [SEG_W-1:0] seg_idx, idx_n;
   logic             rej_n;

   logic [CNT_W-1:0] tick_cnt;
   logic             tick;

   logic [NUM_SEG-1:0] seg_en;
   logic [NUM_SEG-1:0] seg_slope;
   logic [X_W-1:0]     seg_c    [NUM_SEG];
   logic [X_W-1:0]     seg_xmin [NUM_SEG];
   logic [X_W-1:0]     seg_xmax [NUM_SEG];

   logic [X_W-1:0] nx;
   logic [Y_W-1:0] ny;
   logic           step_ok;
   logic [X_W-1:0] cand_x, hit_x;
   logic [Y_W-1:0] cand_y, hit_y;
   logic           cand_ok;
   logic [X_W:0]   sum_xy, rhs_slope;
   logic           seg_hit, portal_hit;

   // Free-running movement tick, never restarted by moves
   always_ff @(posedge clock) begin
      if (!resetn)
         tick_cnt <= '0;
      else if (tick)
         tick_cnt <= '0;
      else
         tick_cnt <= tick_cnt + CNT_W'(1);
   end

   assign tick = (tick_cnt == CNT_LAST);

   // Table writes land only while idle so a scan never sees a half-updated entry
   always_ff @(posedge clock) begin
      if (!resetn) begin
         seg_en <= '0;
      end else if (cfg_we && state == IDLE && {1'b0, cfg_idx} < SEG_CNT) begin
         seg_en[cfg_idx]    <= cfg_wdata[3*X_W+1];
         seg_slope[cfg_idx] <= cfg_wdata[3*X_W];
         seg_c[cfg_idx]     <= cfg_wdata[3*X_W-1:2*X_W];
         seg_xmin[cfg_idx]  <= cfg_wdata[2*X_W-1:X_W];
         seg_xmax[cfg_idx]  <= cfg_wdata[X_W-1:0];
      end
   end

   // Candidate position; wrapping or landing on row/column 0 is never a legal step
   always_comb begin
      nx      = dir[0] ? x - X_W'(1) : x + X_W'(1);
      ny      = dir[1] ? y - Y_W'(1) : y + Y_W'(1);
      step_ok = !(dir[0] ? (x == '0) : (x == '1)) &&
                !(dir[1] ? (y == '0) : (y == '1)) &&
                (nx != '0) && (ny != '0);
   end

   always_comb begin
      sum_xy    = {1'b0, cand_x} + {{PAD{1'b0}}, cand_y};
      rhs_slope = {{PAD{1'b0}}, cand_y} + {1'b0, seg_c[seg_idx]};
      seg_hit   = seg_en[seg_idx] &&
                  (cand_x >= seg_xmin[seg_idx]) && (cand_x <= seg_xmax[seg_idx]) &&
                  (seg_slope[seg_idx] ? ({1'b0, cand_x} == rhs_slope)
                                      : (sum_xy == {1'b0, seg_c[seg_idx]}));
   end

`ifdef SPRITE_PORTAL_EN
   assign portal_hit = (seg_idx == '0) && (cand_x == portal_src_x) && (cand_y == portal_src_y);
   assign hit_x      = portal_hit ? portal_dst_x : cand_x;
   assign hit_y      = portal_hit ? portal_dst_y : cand_y;
`else
   assign portal_hit = 1'b0;
   assign hit_x      = cand_x;
   assign hit_y      = cand_y;
`endif

   always_comb begin
      state_n = state;
      idx_n   = seg_idx;
      rej_n   = 1'b0;
      case (state)
         IDLE: begin
            if (move && tick) begin
               state_n = CHECK;
               idx_n   = '0;
            end
         end
         CHECK: begin
            if (!cand_ok) begin
               state_n = IDLE;
               rej_n   = 1'b1;
            end else if (portal_hit || seg_hit) begin
               state_n = ERASE;
            end else if (seg_idx == SEG_LAST) begin
               state_n = IDLE;
               rej_n   = 1'b1;
            end else begin
               idx_n = seg_idx + SEG_W'(1);
            end
         end
         ERASE:   if (erase_done) state_n = UPDATE;
         UPDATE:  state_n = DRAW;
         DRAW:    if (draw_done) state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   // Outputs are registered from the next state so they line up with the state register
   always_ff @(posedge clock) begin
      if (!resetn) begin
         state         <= IDLE;
         seg_idx       <= '0;
         x             <= X_W'(START_X);
         y             <= Y_W'(START_Y);
         cand_x        <= '0;
         cand_y        <= '0;
         cand_ok       <= 1'b0;
         erase_req     <= 1'b0;
         draw_req      <= 1'b0;
         busy          <= 1'b0;
         move_rejected <= 1'b0;
      end else begin
         state         <= state_n;
         seg_idx       <= idx_n;
         erase_req     <= (state_n == ERASE);
         draw_req      <= (state_n == DRAW);
         busy          <= (state_n != IDLE);
         move_rejected <= rej_n;
         if (state == IDLE && state_n == CHECK) begin
            cand_x  <= nx;
            cand_y  <= ny;
            cand_ok <= step_ok;
         end
         if (state == CHECK && state_n == ERASE) begin
            cand_x <= hit_x;
            cand_y <= hit_y;
         end
         if (state == UPDATE) begin
            x <= cand_x;
            y <= cand_y;
         end
      end
   end

endmodule

// File: tb/tb_sprite_path_mover.sv
// Directed bench for sprite_path_mover with TICK_DIV=4; portal cases run when SPRITE_PORTAL_EN is defined.
module tb_sprite_path_mover;

   logic       clock = 1'b0;
   logic       resetn;
   logic       move;
   logic [1:0] dir;
   logic       cfg_we;
   logic [2:0] cfg_idx;
   logic [28:0] cfg_wdata;
   logic       erase_done;
   logic       draw_done;
   logic [8:0] x;
   logic [7:0] y;
   logic       erase_req, draw_req, busy, move_rejected;
`ifdef SPRITE_PORTAL_EN
   logic [8:0] portal_src_x, portal_dst_x;
   logic [7:0] portal_src_y, portal_dst_y;
`endif

   int checkCount = 0;
   int passCount  = 0;

   sprite_path_mover #(.TICK_DIV(4)) dut (
      .clock(clock), .resetn(resetn), .move(move), .dir(dir),
      .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_wdata(cfg_wdata),
      .erase_done(erase_done), .draw_done(draw_done),
`ifdef SPRITE_PORTAL_EN
      .portal_src_x(portal_src_x), .portal_src_y(portal_src_y),
      .portal_dst_x(portal_dst_x), .portal_dst_y(portal_dst_y),
`endif
      .x(x), .y(y), .erase_req(erase_req), .draw_req(draw_req),
      .busy(busy), .move_rejected(move_rejected)
   );

   always #5 clock = ~clock;

   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      checkCount++;
      if (actual === expected)
         passCount++;
      else
         $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
   endtask

   task automatic writeSegment(input logic [2:0] idx, input logic en, input logic slope,
                               input logic [8:0] c, input logic [8:0] xmin, input logic [8:0] xmax);
      cfg_idx   = idx;
      cfg_wdata = {en, slope, c, xmin, xmax};
      cfg_we    = 1'b1;
      @(negedge clock);
      cfg_we    = 1'b0;
   endtask

   // One full move request with prompt handshakes; optionally attempts a table write while busy
   task automatic applyStimulus(input logic [1:0] d, input logic busyWrite, input logic [2:0] wrIdx,
                                output int chk, output logic rej, output logic sawErase);
      int n;
      chk = 0; rej = 1'b0; sawErase = 1'b0;
      move = 1'b1; dir = d;
      n = 0;
      @(negedge clock);
      while (!busy && n < 12) begin @(negedge clock); n++; end
      move = 1'b0;
      checkOutput("move_start", busy, 1);
      n = 0;
      while (busy && !erase_req && !draw_req && n < 20) begin chk++; @(negedge clock); n++; end
      if (erase_req) begin
         sawErase = 1'b1;
         if (busyWrite) begin
            cfg_idx = wrIdx; cfg_wdata = '0; cfg_we = 1'b1;
            @(negedge clock);
            cfg_we = 1'b0;
         end
         erase_done = 1'b1;
         @(negedge clock);
         erase_done = 1'b0;
         n = 0;
         while (!draw_req && n < 8) begin @(negedge clock); n++; end
         checkOutput("draw_seen", draw_req, 1);
         draw_done = 1'b1;
         @(negedge clock);
         draw_done = 1'b0;
         checkOutput("idle_after_draw", busy, 0);
      end else begin
         rej = move_rejected;
         @(negedge clock);
         checkOutput("reject_one_pulse", move_rejected, 0);
      end
   endtask

   int chk, n, s, ex, ey, dx, dy, rejSeen;
   logic rej, se;
   logic [1:0] pdir;
   logic [2:0] useSeg;

   initial begin
      resetn = 1'b0; move = 1'b0; dir = 2'd0; cfg_we = 1'b0; cfg_idx = '0; cfg_wdata = '0;
      erase_done = 1'b0; draw_done = 1'b0;
`ifdef SPRITE_PORTAL_EN
      portal_src_x = '0; portal_src_y = '0; portal_dst_x = '0; portal_dst_y = '0;
`endif
      repeat (2) @(negedge clock);
      checkOutput("reset_x", x, 96);
      checkOutput("reset_y", y, 222);
      checkOutput("reset_erase_req", erase_req, 0);
      checkOutput("reset_draw_req", draw_req, 0);
      checkOutput("reset_busy", busy, 0);
      checkOutput("reset_rejected", move_rejected, 0);
      resetn = 1'b1;
      @(negedge clock);

      writeSegment(3'd0, 1'b1, 1'b0, 9'd318, 9'd96, 9'd122);

      // (95,223) lies left of xmin, so all eight entries are scanned
      applyStimulus(2'd1, 1'b0, 3'd0, chk, rej, se);
      checkOutput("miss_scan_cycles", chk, 8);
      checkOutput("miss_rejected", rej, 1);
      checkOutput("miss_no_erase", se, 0);
      checkOutput("miss_x", x, 96);
      checkOutput("miss_y", y, 222);

      // Valid step with a slow eraser
      move = 1'b1; dir = 2'd2; n = 0;
      @(negedge clock);
      while (!busy && n < 12) begin @(negedge clock); n++; end
      move = 1'b0;
      checkOutput("valid_busy", busy, 1);
      chk = 0; n = 0;
      while (busy && !erase_req && n < 20) begin chk++; @(negedge clock); n++; end
      checkOutput("valid_check_cycles", chk, 1);
      repeat (3) @(negedge clock);
      checkOutput("erase_held", erase_req, 1);
      checkOutput("x_held_during_erase", x, 96);
      erase_done = 1'b1;
      @(negedge clock);
      erase_done = 1'b0;
      checkOutput("erase_released", erase_req, 0);
      @(negedge clock);
      checkOutput("step_x", x, 97);
      checkOutput("step_y", y, 221);
      checkOutput("draw_req_on", draw_req, 1);
      repeat (2) @(negedge clock);
      checkOutput("draw_held", draw_req, 1);
      draw_done = 1'b1;
      @(negedge clock);
      draw_done = 1'b0;
      checkOutput("draw_released", draw_req, 0);
      checkOutput("step_idle", busy, 0);

      for (int i = 0; i < 25; i++) applyStimulus(2'd2, 1'b0, 3'd0, chk, rej, se);
      checkOutput("walk_x", x, 122);
      checkOutput("walk_y", y, 196);

      applyStimulus(2'd2, 1'b0, 3'd0, chk, rej, se);
      checkOutput("xmax_rejected", rej, 1);
      checkOutput("xmax_scan_cycles", chk, 8);
      checkOutput("xmax_x", x, 122);
      applyStimulus(2'd1, 1'b0, 3'd0, chk, rej, se);
      checkOutput("back_accepted", se, 1);
      checkOutput("back_x", x, 121);
      checkOutput("back_y", y, 197);
      ex = 121; ey = 197; pdir = 2'd1; useSeg = 3'd0;

`ifdef SPRITE_PORTAL_EN
      portal_src_x = 9'd122; portal_src_y = 8'd196;
      portal_dst_x = 9'd127; portal_dst_y = 8'd69;
      applyStimulus(2'd2, 1'b0, 3'd0, chk, rej, se);
      checkOutput("portal_accepted", se, 1);
      checkOutput("portal_x", x, 127);
      checkOutput("portal_y", y, 69);
      portal_src_x = '0; portal_src_y = '0;
      writeSegment(3'd2, 1'b1, 1'b1, 9'd60, 9'd0, 9'd319);
      ex = 127; ey = 69; pdir = 2'd2; useSeg = 3'd2;
`endif
      dx = pdir[0] ? -1 : 1;
      dy = pdir[1] ? -1 : 1;

      // A write while busy must not disable the segment in use
      applyStimulus(pdir, 1'b1, useSeg, chk, rej, se);
      ex += dx; ey += dy;
      checkOutput("busywr_step_x", x, ex);
      applyStimulus(pdir, 1'b0, 3'd0, chk, rej, se);
      ex += dx; ey += dy;
      checkOutput("busywr_table_kept", se, 1);
      checkOutput("busywr_x", x, ex);
      checkOutput("busywr_y", y, ey);

      // Held move with instant handshakes: one step per accepted tick, a step spans two ticks
      erase_done = 1'b1; draw_done = 1'b1; move = 1'b1; dir = pdir; rejSeen = 0;
      repeat (20) begin
         @(negedge clock);
         if (move_rejected) rejSeen++;
      end
      move = 1'b0;
      n = 0;
      while (busy && n < 10) begin @(negedge clock); n++; end
      erase_done = 1'b0; draw_done = 1'b0;
      checkOutput("tick_settled", busy, 0);
      s = pdir[0] ? ex - int'(x) : int'(x) - ex;
      checkOutput("tick_at_most", s <= 3, 1);
      checkOutput("tick_at_least", s >= 2, 1);
      checkOutput("tick_y", y, ey + dy * s);
      checkOutput("tick_no_reject", rejSeen, 0);

      // Reset while drawing
      move = 1'b1; dir = pdir; n = 0;
      @(negedge clock);
      while (!busy && n < 12) begin @(negedge clock); n++; end
      move = 1'b0;
      n = 0;
      while (!erase_req && n < 20) begin @(negedge clock); n++; end
      erase_done = 1'b1;
      @(negedge clock);
      erase_done = 1'b0;
      n = 0;
      while (!draw_req && n < 8) begin @(negedge clock); n++; end
      checkOutput("draw_before_reset", draw_req, 1);
      resetn = 1'b0;
      @(negedge clock);
      resetn = 1'b1;
      checkOutput("rst_draw_req", draw_req, 0);
      checkOutput("rst_x", x, 96);
      checkOutput("rst_y", y, 222);
      checkOutput("rst_busy", busy, 0);
      applyStimulus(2'd2, 1'b0, 3'd0, chk, rej, se);
      checkOutput("table_cleared_reject", rej, 1);
      checkOutput("table_cleared_x", x, 96);

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
